// File: rtl/write_back_stage.sv
// Registered write-back stage: latches the MEM/WB bundle, selects the result
// source, extracts and extends loads, and waits for late memory data.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   IN_VALID            MEM/WB bundle present this cycle
//   STALL, FLUSH        hazard hold (blocks capture), discard captured/pending
//   WB_SEL              result source: 00 ALU, 01 MEM, 10 LINK, 11 IMM
//   REG_WRITE, DEST_REG instruction write enable and destination index
//   ALU_RESULT, READ_DATA, LINK_ADDR, IMM_VALUE   candidate results
//   READ_VALID          READ_DATA valid this cycle
//   LOAD_SIZE, LOAD_UNSIGNED, BYTE_OFFSET         load extraction controls
//   WRITE_EN, WRITE_REG, WRITE_DATA               register-file write port
//   WB_BUSY             waiting on memory; upstream must hold
module write_back_stage #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 5,
    parameter bit ZERO_REG_DISCARD = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    input  logic                  STALL,
    input  logic                  FLUSH,
    input  logic [1:0]            WB_SEL,
    input  logic                  REG_WRITE,
    input  logic [ADDR_WIDTH-1:0] DEST_REG,
    input  logic [DATA_WIDTH-1:0] ALU_RESULT,
    input  logic [DATA_WIDTH-1:0] READ_DATA,
    input  logic                  READ_VALID,
    input  logic [DATA_WIDTH-1:0] LINK_ADDR,
    input  logic [DATA_WIDTH-1:0] IMM_VALUE,
    input  logic [1:0]            LOAD_SIZE,
    input  logic                  LOAD_UNSIGNED,
    input  logic [1:0]            BYTE_OFFSET,
    output logic                  WRITE_EN,
    output logic [ADDR_WIDTH-1:0] WRITE_REG,
    output logic [DATA_WIDTH-1:0] WRITE_DATA,
    output logic                  WB_BUSY
);

    typedef enum logic {
        S_IDLE,
        S_WAIT_MEM
    } state_t;

    state_t                state_q, state_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [ADDR_WIDTH-1:0] pdest_q, pdest_d;
    logic                  prw_q, prw_d;
    logic [1:0]            psize_q, psize_d;
    logic                  puns_q, puns_d;
    logic [1:0]            poff_q, poff_d;

    logic                  capture;
    logic [DATA_WIDTH-1:0] sel_result;

    function automatic logic [DATA_WIDTH-1:0] extend(
        input logic [DATA_WIDTH-1:0] d,
        input logic [1:0]            sz,
        input logic                  uns,
        input logic [1:0]            off
    );
        logic [31:0]           w;
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        w = d[31:0];
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        // Fill with the sign bit first, then overlay the field.
        unique case (sz)
            2'b00: begin
                r       = {DATA_WIDTH{~uns & b[7]}};
                r[7:0]  = b;
            end
            2'b01: begin
                r       = {DATA_WIDTH{~uns & h[15]}};
                r[15:0] = h;
            end
            default: begin
                r       = {DATA_WIDTH{~uns & w[31]}};
                r[31:0] = w;
            end
        endcase
        return r;
    endfunction

    function automatic logic wr_ok(
        input logic                  rw,
        input logic [ADDR_WIDTH-1:0] dst
    );
        return rw & ~(ZERO_REG_DISCARD & (dst == '0));
    endfunction

    assign capture = IN_VALID & ~STALL & ~FLUSH & (state_q == S_IDLE);

    always_comb begin
        sel_result = ALU_RESULT;
        unique case (WB_SEL)
            2'b00:   sel_result = ALU_RESULT;
            2'b01:   sel_result = extend(READ_DATA, LOAD_SIZE,
                                         LOAD_UNSIGNED, BYTE_OFFSET);
            2'b10:   sel_result = LINK_ADDR;
            default: sel_result = IMM_VALUE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wen_d   = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        pdest_d = pdest_q;
        prw_d   = prw_q;
        psize_d = psize_q;
        puns_d  = puns_q;
        poff_d  = poff_q;
        unique case (state_q)
            S_IDLE: begin
                if (capture) begin
                    if (WB_SEL == 2'b01 && !READ_VALID) begin
                        state_d = S_WAIT_MEM;
                        pdest_d = DEST_REG;
                        prw_d   = REG_WRITE;
                        psize_d = LOAD_SIZE;
                        puns_d  = LOAD_UNSIGNED;
                        poff_d  = BYTE_OFFSET;
                    end else begin
                        wen_d   = wr_ok(REG_WRITE, DEST_REG);
                        wreg_d  = DEST_REG;
                        wdata_d = sel_result;
                    end
                end
            end
            default: begin
                // FLUSH wins over a same-cycle READ_VALID.
                if (FLUSH) begin
                    state_d = S_IDLE;
                end else if (READ_VALID) begin
                    state_d = S_IDLE;
                    wen_d   = wr_ok(prw_q, pdest_q);
                    wreg_d  = pdest_q;
                    wdata_d = extend(READ_DATA, psize_q, puns_q, poff_q);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            wen_q   <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            pdest_q <= '0;
            prw_q   <= 1'b0;
            psize_q <= 2'b00;
            puns_q  <= 1'b0;
            poff_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            pdest_q <= pdest_d;
            prw_q   <= prw_d;
            psize_q <= psize_d;
            puns_q  <= puns_d;
            poff_q  <= poff_d;
        end
    end

    assign WRITE_EN   = wen_q;
    assign WRITE_REG  = wreg_q;
    assign WRITE_DATA = wdata_q;
    assign WB_BUSY    = (state_q == S_WAIT_MEM);

endmodule
